// File: rtl/uart_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_ctrl
//
// Turns the byte stream from a UART receiver into length-checked,
// checksum-checked frames of up to 32 payload bytes (256 bits).
//
// Frame layout on the wire: SOF, LEN, PAYLOAD[0..LEN-1], CSUM.
// CSUM is the 8-bit wrap-around sum of LEN and all payload bytes.
//
// A finished frame is held on the outputs until the consumer raises
// i_Frame_Ready. Any bytes that arrive while a frame is held are dropped
// and counted.
//
// Ports
//   i_Clock        system clock
//   reset          synchronous, active-high reset
//   i_RX_DV        single-cycle byte-valid strobe from the receiver
//   i_RX_Byte      received byte, valid when i_RX_DV=1
//   i_Frame_Ready  consumer accepts the held frame
//   o_Frame_Valid  a completed frame is held
//   o_Frame_Data   payload; byte k is at [8k+7:8k]; unused bytes are 0
//   o_Frame_Len    payload length, 1..32
//   o_Err_Pulse    one-cycle pulse when a frame is aborted
//   o_Err_Code     01 bad length, 10 checksum fail, 11 timeout (sticky)
//   o_Drop_Count   bytes dropped while a frame is held (saturating)
//   o_Busy         high in every state except HUNT
// -----------------------------------------------------------------------------
module uart_rx_frame_ctrl #(
  parameter logic [7:0] SOF_BYTE     = 8'hA5,
  parameter int         MAX_LEN      = 32,
  parameter int         TIMEOUT_CLKS = 21700
) (
  input  logic         i_Clock,
  input  logic         reset,
  input  logic         i_RX_DV,
  input  logic [7:0]   i_RX_Byte,
  input  logic         i_Frame_Ready,
  output logic         o_Frame_Valid,
  output logic [255:0] o_Frame_Data,
  output logic [5:0]   o_Frame_Len,
  output logic         o_Err_Pulse,
  output logic [1:0]   o_Err_Code,
  output logic [7:0]   o_Drop_Count,
  output logic         o_Busy
);

  localparam int               TMO_W     = $clog2(TIMEOUT_CLKS);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);
  localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  typedef enum logic [2:0] {
    S_HUNT,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_HOLD
  } state_t;

  state_t             state_q;
  logic [255:0]       buf_q;
  logic [5:0]         len_q;
  logic [5:0]         idx_q;
  logic [7:0]         sum_q;
  logic [TMO_W-1:0]   tmo_q;

  logic               valid_q;
  logic [255:0]       data_q;
  logic [5:0]         flen_q;
  logic               err_pulse_q;
  logic [1:0]         err_code_q;
  logic [7:0]         drop_q;
  logic               busy_q;

  logic               in_frame;
  logic               tmo_expire;
  logic [7:0]         sum_d;
  logic [5:0]         idx_d;
  logic [7:0]         drop_d;

  // The inter-byte timer only runs while a frame is being collected.
  assign in_frame   = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CSUM);
  // A byte arriving on the expiry cycle is accepted instead of timing out.
  assign tmo_expire = in_frame && !i_RX_DV && (tmo_q == TMO_LAST);
  assign sum_d      = sum_q + i_RX_Byte;
  assign idx_d      = idx_q + 6'd1;
  assign drop_d     = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;

  always_ff @(posedge i_Clock) begin
    if (reset) begin
      state_q     <= S_HUNT;
      buf_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      tmo_q       <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      flen_q      <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= '0;
      drop_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      err_pulse_q <= 1'b0;

      // Every byte restarts the timer; idle clocks advance it inside a frame.
      // Entering LEN always happens on a byte, so entry clears it too.
      if (i_RX_DV) begin
        tmo_q <= '0;
      end else if (in_frame) begin
        tmo_q <= tmo_q + TMO_ONE;
      end

      if (tmo_expire) begin
        state_q     <= S_HUNT;
        busy_q      <= 1'b0;
        err_pulse_q <= 1'b1;
        err_code_q  <= ERR_TMO;
        tmo_q       <= '0;
      end else begin
        case (state_q)
          S_HUNT: begin
            if (i_RX_DV && (i_RX_Byte == SOF_BYTE)) begin
              buf_q   <= '0;
              state_q <= S_LEN;
              busy_q  <= 1'b1;
            end
          end

          S_LEN: begin
            if (i_RX_DV) begin
              if ((i_RX_Byte == 8'd0) || (i_RX_Byte > MAX_LEN_B)) begin
                state_q     <= S_HUNT;
                busy_q      <= 1'b0;
                err_pulse_q <= 1'b1;
                err_code_q  <= ERR_LEN;
              end else begin
                len_q   <= i_RX_Byte[5:0];
                sum_q   <= i_RX_Byte;
                idx_q   <= '0;
                state_q <= S_PAYLOAD;
              end
            end
          end

          S_PAYLOAD: begin
            if (i_RX_DV) begin
              buf_q[{idx_q[4:0], 3'b000} +: 8] <= i_RX_Byte;
              sum_q <= sum_d;
              idx_q <= idx_d;
              if (idx_d == len_q) begin
                state_q <= S_CSUM;
              end
            end
          end

          S_CSUM: begin
            if (i_RX_DV) begin
              if (i_RX_Byte == sum_q) begin
                data_q  <= buf_q;
                flen_q  <= len_q;
                valid_q <= 1'b1;
                state_q <= S_HOLD;
              end else begin
                state_q     <= S_HUNT;
                busy_q      <= 1'b0;
                err_pulse_q <= 1'b1;
                err_code_q  <= ERR_CSUM;
              end
            end
          end

          S_HOLD: begin
            // Bytes are dropped even on the cycle the frame is released.
            if (i_RX_DV) begin
              drop_q <= drop_d;
            end
            if (i_Frame_Ready) begin
              valid_q <= 1'b0;
              state_q <= S_HUNT;
              busy_q  <= 1'b0;
            end
          end

          default: begin
            state_q <= S_HUNT;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_Frame_Valid = valid_q;
  assign o_Frame_Data  = data_q;
  assign o_Frame_Len   = flen_q;
  assign o_Err_Pulse   = err_pulse_q;
  assign o_Err_Code    = err_code_q;
  assign o_Drop_Count  = drop_q;
  assign o_Busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for uart_rx_frame_ctrl.
// Directed byte sequences drive the receiver side; every frame or abort the
// DUT should produce is queued as an expected event when its bytes are sent,
// and a negedge monitor pops and compares each event as the DUT reports it.
// -----------------------------------------------------------------------------
module tb_uart_rx_frame_ctrl;

  localparam int T = 21700;

  logic         clk     = 1'b0;
  logic         reset   = 1'b1;
  logic         rx_dv   = 1'b0;
  logic [7:0]   rx_byte = 8'h00;
  logic         ready   = 1'b0;

  logic         o_Frame_Valid;
  logic [255:0] o_Frame_Data;
  logic [5:0]   o_Frame_Len;
  logic         o_Err_Pulse;
  logic [1:0]   o_Err_Code;
  logic [7:0]   o_Drop_Count;
  logic         o_Busy;

  uart_rx_frame_ctrl #(
    .SOF_BYTE     (8'hA5),
    .MAX_LEN      (32),
    .TIMEOUT_CLKS (T)
  ) dut (
    .i_Clock       (clk),
    .reset         (reset),
    .i_RX_DV       (rx_dv),
    .i_RX_Byte     (rx_byte),
    .i_Frame_Ready (ready),
    .o_Frame_Valid (o_Frame_Valid),
    .o_Frame_Data  (o_Frame_Data),
    .o_Frame_Len   (o_Frame_Len),
    .o_Err_Pulse   (o_Err_Pulse),
    .o_Err_Code    (o_Err_Code),
    .o_Drop_Count  (o_Drop_Count),
    .o_Busy        (o_Busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit           is_err;
    logic [1:0]   code;
    logic [5:0]   len;
    logic [255:0] data;
  } ev_t;

  ev_t        sb[$];
  logic [7:0] pay [32];

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    tick(1);
    rx_dv   = 1'b0;
    $display("tx byte %02h  valid=%0b err=%0b code=%0d busy=%0b", b, o_Frame_Valid, o_Err_Pulse, o_Err_Code, o_Busy);
  endtask

  task automatic push_err(input logic [1:0] c);
    ev_t e;
    e.is_err = 1'b1;
    e.code   = c;
    e.len    = '0;
    e.data   = '0;
    sb.push_back(e);
  endtask

  // Sends SOF, LEN, pay[0..n-1] and the model checksum; returns just after
  // the checksum byte's edge, where the frame should already be valid.
  task automatic send_frame(input int n);
    ev_t        e;
    logic [7:0] s;
    s        = 8'(n);
    e.is_err = 1'b0;
    e.code   = '0;
    e.len    = 6'(n);
    e.data   = '0;
    for (int k = 0; k < n; k++) begin
      e.data[8*k +: 8] = pay[k];
      s = s + pay[k];
    end
    sb.push_back(e);
    send(8'hA5);
    tick(1);
    send(8'(n));
    tick(1);
    for (int k = 0; k < n; k++) begin
      send(pay[k]);
    end
    send(s);
  endtask

  // Monitor: pops the scoreboard on each abort pulse and each new frame.
  logic         prev_valid = 1'b0;
  logic         prev_err   = 1'b0;
  logic [255:0] prev_data  = '0;
  ev_t          mon_e;

  always @(negedge clk) begin
    if (!reset) begin
      if (o_Err_Pulse) begin
        chk("err_pulse_width", prev_err, 1'b0);
        chk("sb_has_err_evt", (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("evt_is_err", mon_e.is_err, 1'b1);
          chk("err_code", o_Err_Code, mon_e.code);
          $display("rx abort code=%0d", o_Err_Code);
        end
      end
      if (o_Frame_Valid && !prev_valid) begin
        chk("sb_has_frame_evt", (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("evt_is_frame", mon_e.is_err, 1'b0);
          chk("frame_len", o_Frame_Len, mon_e.len);
          chk("frame_data", o_Frame_Data, mon_e.data);
          $display("rx frame len=%0d data=%0h", o_Frame_Len, o_Frame_Data);
        end
      end
      if (o_Frame_Valid && prev_valid) begin
        chk("hold_data_stable", o_Frame_Data, prev_data);
      end
    end
    prev_valid = o_Frame_Valid;
    prev_err   = o_Err_Pulse;
    prev_data  = o_Frame_Data;
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, o_Frame_Valid, 1'b0);
    chk({tag, "_data"},  o_Frame_Data,  '0);
    chk({tag, "_len"},   o_Frame_Len,   6'd0);
    chk({tag, "_pulse"}, o_Err_Pulse,   1'b0);
    chk({tag, "_code"},  o_Err_Code,    2'd0);
    chk({tag, "_drop"},  o_Drop_Count,  8'd0);
    chk({tag, "_busy"},  o_Busy,        1'b0);
  endtask

  initial begin
    ev_t ex;

    // Reset state
    reset = 1'b1;
    tick(3);
    chk_all_zero("reset");
    reset = 1'b0;
    tick(2);

    // Good frame with consumer ready: valid for exactly one cycle
    ready  = 1'b1;
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    send_frame(3);
    chk("good_valid", o_Frame_Valid, 1'b1);
    chk("good_low24", o_Frame_Data[23:0], 24'h332211);
    tick(1);
    chk("good_valid_1cyc", o_Frame_Valid, 1'b0);
    chk("good_busy_done", o_Busy, 1'b0);
    chk("good_no_err", o_Err_Code, 2'd0);
    tick(2);

    // Bad checksum
    push_err(2'b10);
    send(8'hA5); tick(1); send(8'h02); tick(1);
    send(8'h10); send(8'h20); send(8'h00);
    chk("csum_pulse", o_Err_Pulse, 1'b1);
    chk("csum_code", o_Err_Code, 2'b10);
    chk("csum_valid", o_Frame_Valid, 1'b0);
    chk("csum_busy", o_Busy, 1'b0);
    tick(1);
    chk("csum_pulse_end", o_Err_Pulse, 1'b0);
    chk("csum_code_hold", o_Err_Code, 2'b10);
    pay[0] = 8'h7F;
    send_frame(1);
    chk("after_csum_valid", o_Frame_Valid, 1'b1);
    chk("after_csum_byte0", o_Frame_Data[7:0], 8'h7F);
    tick(2);

    // Bad lengths and the maximum length
    push_err(2'b01);
    send(8'hA5); tick(1); send(8'h00);
    chk("len0_pulse", o_Err_Pulse, 1'b1);
    chk("len0_code", o_Err_Code, 2'b01);
    tick(2);
    push_err(2'b01);
    send(8'hA5); tick(1); send(8'h21);
    chk("len33_pulse", o_Err_Pulse, 1'b1);
    chk("len33_code", o_Err_Code, 2'b01);
    tick(2);
    for (int k = 0; k < 32; k++) pay[k] = 8'h01;
    send_frame(32);
    chk("len32_valid", o_Frame_Valid, 1'b1);
    chk("len32_len", o_Frame_Len, 6'd32);
    tick(2);

    // Timeout after TIMEOUT_CLKS idle clocks
    push_err(2'b11);
    send(8'hA5); tick(1); send(8'h02); tick(1); send(8'h55);
    tick(T - 1);
    chk("tmo_before_pulse", o_Err_Pulse, 1'b0);
    chk("tmo_before_busy", o_Busy, 1'b1);
    tick(1);
    chk("tmo_pulse", o_Err_Pulse, 1'b1);
    chk("tmo_code", o_Err_Code, 2'b11);
    chk("tmo_busy", o_Busy, 1'b0);
    tick(2);

    // Byte arriving on the expiry cycle wins
    ex.is_err = 1'b0; ex.code = '0; ex.len = 6'd2;
    ex.data = '0; ex.data[15:0] = 16'h6655;
    sb.push_back(ex);
    send(8'hA5); tick(1); send(8'h02); tick(1); send(8'h55);
    tick(T - 1);
    send(8'h66);
    chk("expiry_dv_no_pulse", o_Err_Pulse, 1'b0);
    chk("expiry_dv_busy", o_Busy, 1'b1);
    tick(1);
    send(8'hBD);
    chk("expiry_dv_valid", o_Frame_Valid, 1'b1);
    tick(2);

    // Backpressure: held frame, dropped bytes, drop on the release cycle
    ready  = 1'b0;
    pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF;
    send_frame(4);
    chk("bp_valid", o_Frame_Valid, 1'b1);
    tick(3);
    chk("bp_still_valid", o_Frame_Valid, 1'b1);
    send(8'h00); tick(1);
    send(8'hA5); tick(1);
    chk("bp_drop2", o_Drop_Count, 8'd2);
    chk("bp_data_held", o_Frame_Data[31:0], 32'hEFBEADDE);
    chk("bp_len_held", o_Frame_Len, 6'd4);
    ready = 1'b1;
    send(8'h77);
    chk("bp_valid_clear", o_Frame_Valid, 1'b0);
    chk("bp_busy_clear", o_Busy, 1'b0);
    chk("bp_drop3", o_Drop_Count, 8'd3);
    tick(2);

    // Reset mid-frame, then garbage before a good frame
    send(8'hA5); tick(1); send(8'h04); tick(1); send(8'h01);
    chk("mid_busy", o_Busy, 1'b1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk_all_zero("midreset");
    send(8'h00); tick(1); send(8'hFF); tick(1);
    chk("garbage_pulse", o_Err_Pulse, 1'b0);
    chk("garbage_busy", o_Busy, 1'b0);
    pay[0] = 8'hC3; pay[1] = 8'h3C;
    send_frame(2);
    chk("post_reset_valid", o_Frame_Valid, 1'b1);
    tick(4);

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
